rpll_reconfig_ctrl: RTL and testbench
=====================================

Name: rpll_reconfig_ctrl

Overview:
Sequencer for the on-chip rPLL: it owns the PLL RESET pin and the dynamic divider selects IDSEL, FBDSEL and ODSEL.
- On power-up it holds the PLL in reset, then qualifies LOCK.
- On request it applies a new divider set: reset, reprogram, re-lock.
- It retries on lock timeout and re-locks after lock loss.
- It runs in the PLL input clock domain (27 MHz crystal) and sits beside the PLL wrapper, which is built with DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true".

Parameters:
RST_CYCLES, 16, PLL reset pulse width in clkin cycles (min 2)
LOCK_TIMEOUT, 65535, max cycles from reset release to qualified lock (~2.4 ms)
LOCK_STABLE, 256, consecutive synced-LOCK-high cycles required to declare locked
MAX_RETRY, 3, reset/re-lock attempts after the first before FAIL
CNT_W, 16, counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)
DEF_IDIV, 8, power-up input divider select (logical value)
DEF_FBDIV, 1, power-up feedback divider select (logical value)
DEF_ODSEL, 6'd0, power-up raw ODSEL code

Ports:
clkin  in  1  27 MHz reference; the only clock
reset  in  1  asynchronous, active-high
cfg_valid  in  1  new divider set offered
cfg_ready  out  1  controller can accept a set
cfg_idiv  in  6  logical IDIV_SEL
cfg_fbdiv  in  6  logical FBDIV_SEL
cfg_odsel  in  6  raw ODSEL code, passed through unchanged
pll_lock  in  1  rPLL LOCK, asynchronous to clkin
pll_reset  out  1  to rPLL RESET
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
locked  out  1  qualified, stable lock
busy  out  1  sequence in progress
err  out  1  sticky: retries exhausted
retry_cnt  out  2  retries used in the current sequence

Behaviour:
- pll_lock passes through a 2-FF synchroniser (lock_s); all decisions use lock_s.
- Encoding: pll_idsel = 63 - idiv and pll_fbdsel = 63 - fbdiv (inverted dynamic encoding); pll_odsel = raw code. All three are registered.
- Reset (async) values:
  - state = RESET_HOLD, pll_reset = 1, counters = 0
  - selects = encoded DEF_* values
  - locked = 0, busy = 1, err = 0, cfg_ready = 0, retry_cnt = 0
- States:
  - RUN: locked = 1, busy = 0, cfg_ready = 1.
    - If lock_s = 0 for one cycle: locked drops next cycle, retry_cnt = 0, go RESET_HOLD with the same config.
    - If cfg_valid & cfg_ready: latch cfg_*, go APPLY.
    - If lock loss and a handshake occur in the same cycle, the handshake wins: the new config is accepted.
  - APPLY (1 cycle): pll_reset = 1 and locked = 0 in this cycle; selects unchanged. Next cycle selects update, go RESET_HOLD. Dividers therefore never change while the PLL is out of reset.
  - RESET_HOLD: pll_reset = 1 for exactly RST_CYCLES cycles, then pll_reset = 0, timeout counter cleared, go WAIT_LOCK.
  - WAIT_LOCK: timeout counter increments every cycle. lock_s = 1 → go STABLE with the stable counter cleared.
  - STABLE: stable counter increments while lock_s = 1; the timeout counter keeps running.
    - lock_s = 0 → back to WAIT_LOCK; the timeout counter is not cleared.
    - Stable counter reaches LOCK_STABLE-1 → go RUN; locked = 1 the following cycle; retry_cnt holds its final value.
  - Timeout (counter = LOCK_TIMEOUT-1 in WAIT_LOCK or STABLE):
    - If retry_cnt < MAX_RETRY: retry_cnt++, go RESET_HOLD.
    - Otherwise go FAIL.
  - FAIL: err = 1, pll_reset = 1 (PLL parked), locked = 0, busy = 0, cfg_ready = 1. A handshake clears err and retry_cnt and goes to APPLY.
- cfg_ready is 1 only in RUN and FAIL. cfg_valid outside those states is ignored and not queued; the requester holds cfg_valid.
- Assertion of reset mid-sequence aborts immediately and reloads the DEF_* values.
- Latency from handshake to locked (ideal PLL locking t_lock cycles after release) = 1 + RST_CYCLES + 2 (sync) + t_lock + LOCK_STABLE cycles, ±1 boundary.

Decomposition:
- Package rpll_ctrl_pkg: state enum (RESET_HOLD, WAIT_LOCK, STABLE, RUN, APPLY, FAIL); function enc_div(logic [5:0]) returning 63 - v; default select constants.
- One sub-module: sync_2ff, generic 1-bit two-flop synchroniser, reused by other CDC inputs.

Test Plan:
- Power-up, PLL model asserts LOCK 500 cycles after reset release → pll_reset high for 16 cycles; locked rises 500+2+256 (±1) cycles after release; pll_idsel = 55, pll_fbdsel = 62.
- In RUN, offer cfg_idiv = 2, cfg_fbdiv = 9, cfg_odsel = 6'h08 → cfg_ready drops; pll_reset rises before selects change; selects = 61/54/08 during hold; re-lock; cfg_ready returns.
- LOCK never asserts → 4 timeouts (retry_cnt 1, 2, 3), then FAIL with err = 1, pll_reset = 1, cfg_ready = 1; a new config clears err.
- LOCK glitches low for 3 cycles mid-STABLE → stable count restarts; timeout count continues; locked is delayed by the glitch, with no retry if within the timeout.
- LOCK drops for 1 cycle in RUN → locked = 0 the next cycle; full reset/re-lock with unchanged selects; retry_cnt = 0.
- Assert reset during WAIT_LOCK after a reconfig → all outputs return to reset values; selects revert to the DEF_* encodings.

Source files
------------

// File: rtl/rpll_reconfig_ctrl_pkg.sv
// Shared types and helpers for the rPLL reconfiguration sequencer.
// The rPLL dynamic divider pins take an inverted encoding of the logical divider value.
package rpll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    APPLY,
    FAIL
  } state_t;

  localparam logic [5:0] DEF_IDIV_VAL  = 6'd8;
  localparam logic [5:0] DEF_FBDIV_VAL = 6'd1;
  localparam logic [5:0] DEF_ODSEL_VAL = 6'd0;

  // IDSEL/FBDSEL pins expect 63 minus the logical divider select.
  function automatic logic [5:0] enc_div(input logic [5:0] v);
    return 6'd63 - v;
  endfunction

endpackage

// File: rtl/rpll_reconfig_ctrl_if.sv
// Divider-set request handshake between a requester and the rPLL sequencer.
interface rpll_reconfig_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idiv;
  logic [5:0] cfg_fbdiv;
  logic [5:0] cfg_odsel;

  modport master (
    output cfg_valid,
    output cfg_idiv,
    output cfg_fbdiv,
    output cfg_odsel,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idiv,
    input  cfg_fbdiv,
    input  cfg_odsel,
    output cfg_ready
  );
endinterface

// File: rtl/rpll_reconfig_ctrl_sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rpll_reconfig_ctrl.sv
// rPLL reset/divider sequencer: power-up lock qualification, runtime reconfiguration,
// retry on lock timeout and automatic re-lock after lock loss.
module rpll_reconfig_ctrl
  import rpll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 16,
  parameter logic [5:0]  DEF_IDIV     = DEF_IDIV_VAL,
  parameter logic [5:0]  DEF_FBDIV    = DEF_FBDIV_VAL,
  parameter logic [5:0]  DEF_ODSEL    = DEF_ODSEL_VAL
) (
  input  logic                  clkin,
  input  logic                  reset,
  rpll_reconfig_ctrl_if.slave   cfg,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [5:0]            pll_idsel,
  output logic [5:0]            pll_fbdsel,
  output logic [5:0]            pll_odsel,
  output logic                  locked,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            retry_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  if (RST_CYCLES < 2) begin : g_chk_rst
    $error("RST_CYCLES must be at least 2");
  end
  if (MAX_RETRY > 3) begin : g_chk_retry
    $error("MAX_RETRY must fit the 2-bit retry counter");
  end
  if ((64'(1) << CNT_W) <= 64'(LOCK_TIMEOUT)) begin : g_chk_cnt
    $error("CNT_W too narrow for LOCK_TIMEOUT");
  end

  state_t           state;
  state_t           state_nx;
  logic             lock_s;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] stb_cnt;
  logic [5:0]       new_idiv;
  logic [5:0]       new_fbdiv;
  logic [5:0]       new_odsel;
  logic             hs;
  logic             hold_done;
  logic             tmo_hit;
  logic             stb_done;
  logic             retry_left;
  logic             lock_wait;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  assign hs         = cfg.cfg_valid & cfg.cfg_ready;
  assign hold_done  = (hold_cnt == HOLD_LAST);
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign stb_done   = (stb_cnt == STB_LAST);
  assign retry_left = (retry_cnt < RETRY_MAX);
  assign lock_wait  = (state == WAIT_LOCK) || (state == STABLE);

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state <= RESET_HOLD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RESET_HOLD: if (hold_done) state_nx = WAIT_LOCK;
      WAIT_LOCK: begin
        if (tmo_hit)     state_nx = retry_left ? RESET_HOLD : FAIL;
        else if (lock_s) state_nx = STABLE;
      end
      // A lock that qualifies on the very last timeout cycle is accepted.
      STABLE: begin
        if (lock_s && stb_done) state_nx = RUN;
        else if (tmo_hit)       state_nx = retry_left ? RESET_HOLD : FAIL;
        else if (!lock_s)       state_nx = WAIT_LOCK;
      end
      // Handshake takes precedence over a simultaneous lock loss.
      RUN: begin
        if (hs)           state_nx = APPLY;
        else if (!lock_s) state_nx = RESET_HOLD;
      end
      APPLY:   state_nx = RESET_HOLD;
      FAIL:    if (hs) state_nx = APPLY;
      default: state_nx = RESET_HOLD;
    endcase
  end

  always_comb begin
    pll_reset     = 1'b0;
    locked        = 1'b0;
    busy          = 1'b1;
    err           = 1'b0;
    cfg.cfg_ready = 1'b0;
    unique case (state)
      RESET_HOLD, APPLY: pll_reset = 1'b1;
      RUN: begin
        locked        = 1'b1;
        busy          = 1'b0;
        cfg.cfg_ready = 1'b1;
      end
      FAIL: begin
        pll_reset     = 1'b1;
        busy          = 1'b0;
        err           = 1'b1;
        cfg.cfg_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      stb_cnt    <= '0;
      retry_cnt  <= '0;
      new_idiv   <= DEF_IDIV;
      new_fbdiv  <= DEF_FBDIV;
      new_odsel  <= DEF_ODSEL;
      pll_idsel  <= enc_div(DEF_IDIV);
      pll_fbdsel <= enc_div(DEF_FBDIV);
      pll_odsel  <= DEF_ODSEL;
    end else begin
      hold_cnt <= ((state == RESET_HOLD) && (state_nx == RESET_HOLD)) ? hold_cnt + 1'b1 : '0;
      // Timeout spans WAIT_LOCK and STABLE so lock glitches cannot extend an attempt.
      tmo_cnt  <= lock_wait ? tmo_cnt + 1'b1 : '0;
      stb_cnt  <= ((state == STABLE) && lock_s) ? stb_cnt + 1'b1 : '0;

      if (hs) begin
        retry_cnt <= '0;
        new_idiv  <= cfg.cfg_idiv;
        new_fbdiv <= cfg.cfg_fbdiv;
        new_odsel <= cfg.cfg_odsel;
      end else if ((state == RUN) && !lock_s) begin
        retry_cnt <= '0;
      end else if (lock_wait && (state_nx == RESET_HOLD)) begin
        retry_cnt <= retry_cnt + 2'd1;
      end

      // Selects move only on the APPLY exit edge, when pll_reset is already high.
      if (state == APPLY) begin
        pll_idsel  <= enc_div(new_idiv);
        pll_fbdsel <= enc_div(new_fbdiv);
        pll_odsel  <= new_odsel;
      end
    end
  end

endmodule

// File: tb/tb_rpll_reconfig_ctrl.sv
// Scoreboard bench for rpll_reconfig_ctrl: a per-attempt PLL lock model drives pll_lock,
// a reference model predicts each sequence outcome, a monitor checks locked/err events.
module tb_rpll_reconfig_ctrl;

  localparam int RST_CYCLES   = 16;
  localparam int LOCK_TIMEOUT = 1000;
  localparam int LOCK_STABLE  = 256;
  localparam int MAX_RETRY    = 3;
  localparam int SYNC_LAT     = 2;
  localparam int NEVER        = 1000000;

  typedef struct {
    int t_lock;
    int g_at;
    int g_len;
  } attempt_t;

  typedef struct {
    bit is_fail;
    int idsel;
    int fbdsel;
    int odsel;
    int retry;
    int lat;
  } exp_t;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       locked;
  logic       busy;
  logic       err;
  logic [1:0] retry_cnt;

  rpll_reconfig_ctrl_if cfg_bus ();

  always #5 clkin = ~clkin;

  rpll_reconfig_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16),
    .DEF_IDIV     (6'd8),
    .DEF_FBDIV    (6'd1),
    .DEF_ODSEL    (6'd0)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .cfg        (cfg_bus.slave),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .pll_idsel  (pll_idsel),
    .pll_fbdsel (pll_fbdsel),
    .pll_odsel  (pll_odsel),
    .locked     (locked),
    .busy       (busy),
    .err        (err),
    .retry_cnt  (retry_cnt)
  );

  int       tests = 0;
  int       fails = 0;
  int       cyc = 0;
  attempt_t att_q[$];
  exp_t     sb_q[$];
  attempt_t cur = '{t_lock: 100, g_at: 0, g_len: 0};
  int       pll_cnt = 0;
  logic     drop = 1'b0;
  int       exp_i = 8;
  int       exp_f = 1;
  int       exp_o = 0;

  function automatic attempt_t mk(int t, int g = 0, int l = 0);
    attempt_t a;
    a.t_lock = t;
    a.g_at   = g;
    a.g_len  = l;
    return a;
  endfunction

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit lock_level(attempt_t a, int n);
    return (n >= a.t_lock) && !((a.g_len > 0) && (n >= a.g_at) && (n < a.g_at + a.g_len));
  endfunction

  // Reference: walk the attempts; one succeeds if its final lock rise plus the
  // synchroniser and stability window lands before the timeout expires.
  function automatic exp_t predict(attempt_t plan[$], int i_, int f_, int o_);
    exp_t     e;
    attempt_t a;
    int       last;
    e.is_fail = 1'b1;
    e.idsel   = 63 - i_;
    e.fbdsel  = 63 - f_;
    e.odsel   = o_;
    e.retry   = MAX_RETRY;
    e.lat     = 0;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      a = (k < plan.size()) ? plan[k] : mk(100);
      last = (a.g_len > 0) ? a.g_at + a.g_len : a.t_lock;
      if (a.t_lock < NEVER && last + SYNC_LAT + LOCK_STABLE < LOCK_TIMEOUT) begin
        e.is_fail = 1'b0;
        e.retry   = k;
        e.lat     = last + SYNC_LAT + LOCK_STABLE;
        return e;
      end
    end
    return e;
  endfunction

  task automatic arm(attempt_t plan[$], int i_, int f_, int o_);
    att_q.delete();
    foreach (plan[k]) att_q.push_back(plan[k]);
    sb_q.push_back(predict(plan, i_, f_, o_));
  endtask

  // PLL lock model: counts cycles since RESET release, one behaviour per attempt.
  always @(negedge clkin) begin
    if (pll_reset) begin
      pll_cnt = 0;
    end else begin
      if (pll_cnt == 0) begin
        if (att_q.size() > 0) cur = att_q.pop_front();
        else                  cur = mk(100);
      end
      pll_cnt++;
    end
    pll_lock = !pll_reset && !drop && lock_level(cur, pll_cnt);
  end

  always @(posedge clkin) cyc++;

  logic prev_locked = 1'b0;
  logic prev_err = 1'b0;
  logic prev_rst = 1'b1;
  int   rel_cyc = 0;

  function automatic void check_event(bit is_fail);
    exp_t e;
    int   lat;
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got is_fail=%0d, expected no event", is_fail);
      return;
    end
    e = sb_q.pop_front();
    chk("event_kind", int'(is_fail), int'(e.is_fail));
    chk("ev_idsel", int'(pll_idsel), e.idsel);
    chk("ev_fbdsel", int'(pll_fbdsel), e.fbdsel);
    chk("ev_odsel", int'(pll_odsel), e.odsel);
    chk("ev_retry", int'(retry_cnt), e.retry);
    if (!is_fail && !e.is_fail) begin
      lat = cyc - rel_cyc;
      tests++;
      if (lat < e.lat - 1 || lat > e.lat + 1) begin
        fails++;
        $display("FAIL lock_latency: got %0d, expected %0d +/-1", lat, e.lat);
      end
    end
  endfunction

  always @(negedge clkin) begin
    if (!reset) begin
      if (prev_rst && !pll_reset) rel_cyc = cyc;
      if (locked && !prev_locked) check_event(1'b0);
      if (err && !prev_err)       check_event(1'b1);
    end
    prev_locked = locked;
    prev_err    = err;
    prev_rst    = pll_reset;
  end

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_pll_reset"}, int'(pll_reset), 1);
    chk({tag, "_idsel"}, int'(pll_idsel), 55);
    chk({tag, "_fbdsel"}, int'(pll_fbdsel), 62);
    chk({tag, "_odsel"}, int'(pll_odsel), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_ready"}, int'(cfg_bus.cfg_ready), 0);
    chk({tag, "_retry"}, int'(retry_cnt), 0);
  endtask

  task automatic wait_done(string tag, int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending events after %0d cycles, expected 0", tag, sb_q.size(), bound);
      sb_q.delete();
    end
  endtask

  task automatic apply_cfg(int i_, int f_, int o_, bit from_fail);
    int oi = 63 - exp_i;
    int of = 63 - exp_f;
    int oo = exp_o;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_idiv  = 6'(i_);
    cfg_bus.cfg_fbdiv = 6'(f_);
    cfg_bus.cfg_odsel = 6'(o_);
    chk("hs_ready", int'(cfg_bus.cfg_ready), 1);
    if (from_fail) chk("hs_err_before", int'(err), 1);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    chk("apply_ready", int'(cfg_bus.cfg_ready), 0);
    chk("apply_pll_reset", int'(pll_reset), 1);
    chk("apply_locked", int'(locked), 0);
    chk("apply_err", int'(err), 0);
    chk("apply_idsel_hold", int'(pll_idsel), oi);
    chk("apply_fbdsel_hold", int'(pll_fbdsel), of);
    chk("apply_odsel_hold", int'(pll_odsel), oo);
    tick();
    chk("hold_pll_reset", int'(pll_reset), 1);
    chk("hold_idsel", int'(pll_idsel), 63 - i_);
    chk("hold_fbdsel", int'(pll_fbdsel), 63 - f_);
    chk("hold_odsel", int'(pll_odsel), o_);
    exp_i = i_;
    exp_f = f_;
    exp_o = o_;
  endtask

  initial begin
    attempt_t plan[$];
    int       n;
    int       seen[$];
    int       last_r;
    int       i_, f_, o_, t, sc, k;

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_idiv  = '0;
    cfg_bus.cfg_fbdiv = '0;
    cfg_bus.cfg_odsel = '0;

    repeat (3) tick();
    chk_reset_vals("por");
    plan = {mk(500)};
    arm(plan, 8, 1, 0);
    reset = 1'b0;
    n = 0;
    while (pll_reset && n < 100) begin
      tick();
      n++;
    end
    chk("por_hold_cycles", n, RST_CYCLES);
    wait_done("por", 2000);
    chk("por_locked", int'(locked), 1);
    chk("por_busy", int'(busy), 0);
    chk("por_ready", int'(cfg_bus.cfg_ready), 1);

    plan = {mk(300)};
    arm(plan, 2, 9, 8);
    apply_cfg(2, 9, 8, 1'b0);
    chk("tp_idsel", int'(pll_idsel), 61);
    chk("tp_fbdsel", int'(pll_fbdsel), 54);
    chk("tp_odsel", int'(pll_odsel), 8);
    wait_done("reconfig", 2000);
    chk("reconfig_ready", int'(cfg_bus.cfg_ready), 1);

    plan = {mk(200, 300, 3)};
    arm(plan, 5, 20, 3);
    apply_cfg(5, 20, 3, 1'b0);
    wait_done("glitch", 2000);

    for (int it = 0; it < 6; it++) begin
      i_ = $urandom_range(0, 63);
      f_ = $urandom_range(0, 63);
      o_ = $urandom_range(0, 63);
      sc = $urandom_range(0, 2);
      plan = {};
      if (sc == 0) begin
        plan.push_back(mk($urandom_range(20, 600)));
      end else if (sc == 1) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) plan.push_back(mk(NEVER));
        plan.push_back(mk($urandom_range(20, 600)));
      end else begin
        t = $urandom_range(20, 300);
        plan.push_back(mk(t, t + $urandom_range(10, 200), $urandom_range(1, 5)));
      end
      arm(plan, i_, f_, o_);
      apply_cfg(i_, f_, o_, 1'b0);
      wait_done("rand", 6000);
    end

    plan = {mk(NEVER), mk(NEVER), mk(NEVER), mk(NEVER)};
    arm(plan, 12, 3, 5);
    apply_cfg(12, 3, 5, 1'b0);
    n = 0;
    last_r = 0;
    while (sb_q.size() != 0 && n < 6000) begin
      tick();
      n++;
      if (int'(retry_cnt) != last_r) begin
        last_r = int'(retry_cnt);
        seen.push_back(last_r);
      end
    end
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL fail_seq_timeout: got %0d pending events, expected 0", sb_q.size());
      sb_q.delete();
    end
    chk("retry_steps", seen.size(), 3);
    for (int j = 0; j < seen.size() && j < 3; j++) chk("retry_step_val", seen[j], j + 1);
    tick();
    chk("fail_err", int'(err), 1);
    chk("fail_pll_reset", int'(pll_reset), 1);
    chk("fail_ready", int'(cfg_bus.cfg_ready), 1);
    chk("fail_locked", int'(locked), 0);
    chk("fail_busy", int'(busy), 0);
    plan = {mk(150)};
    arm(plan, 30, 7, 1);
    apply_cfg(30, 7, 1, 1'b1);
    chk("recover_retry", int'(retry_cnt), 0);
    wait_done("recover", 2000);

    plan = {mk(150)};
    arm(plan, exp_i, exp_f, exp_o);
    drop = 1'b1;
    tick();
    drop = 1'b0;
    tick();
    chk("loss_locked_still", int'(locked), 1);
    tick();
    chk("loss_locked_drop", int'(locked), 0);
    chk("loss_pll_reset", int'(pll_reset), 1);
    chk("loss_retry", int'(retry_cnt), 0);
    chk("loss_idsel_same", int'(pll_idsel), 63 - exp_i);
    wait_done("loss", 2000);

    plan = {mk(NEVER)};
    arm(plan, 40, 40, 40);
    apply_cfg(40, 40, 40, 1'b0);
    n = 0;
    while (pll_reset && n < 100) begin
      tick();
      n++;
    end
    repeat (50) tick();
    chk("midseq_busy", int'(busy), 1);
    chk("midseq_pll_reset", int'(pll_reset), 0);
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    sb_q.delete();
    exp_i = 8;
    exp_f = 1;
    exp_o = 0;
    plan = {mk(120)};
    arm(plan, 8, 1, 0);
    tick();
    reset = 1'b0;
    wait_done("abort_relock", 2000);
    chk("final_locked", int'(locked), 1);
    chk("final_pending", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
